// File: rtl/fifo_pkg.sv
// Shared defaults for the flow-controlled FIFO family and the depth derivation helper.
package fifo_pkg;
    localparam int FIFO_DATA_WIDTH = 10;
    localparam int FIFO_ADDR_WIDTH = 3;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction
endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x DATA_WIDTH storage with a synchronous write port and a registered read port.
module fifo_mem_2p
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data_p1
);
    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // Read register: a same-edge write to rd_addr is not visible here (old word is returned).
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data_p1 <= '0;
        else if (rd_en)
            rd_data_p1 <= mem[rd_addr];
    end
endmodule

// File: rtl/fifo_flow_ctrl.sv
// Single-clock FIFO with occupancy count, almost thresholds, sticky error flags and registered read.
module fifo_flow_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] FIFO_data_in,
    input  logic [ADDR_WIDTH:0]   almost_full_th,
    input  logic [ADDR_WIDTH:0]   almost_empty_th,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] FIFO_data_out,
    output logic                  valid_out,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow_err,
    output logic                  underflow_err
);
    localparam int                DEPTH     = fifo_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  ovf_set;
    logic                  unf_set;
    logic                  vld_p1;

    assign full         = (fifo_count == DEPTH_CNT);
    assign empty        = (fifo_count == '0);
    assign almost_full  = (fifo_count >= almost_full_th);
    assign almost_empty = (fifo_count <= almost_empty_th);

    // A pop frees the slot the push needs when full; an empty FIFO never bypasses.
    assign wr_ok   = push & (~full | pop);
    assign rd_ok   = pop & ~empty;
    assign ovf_set = push & full & ~pop;
    assign unf_set = pop & empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Sticky errors: a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            overflow_err  <= ovf_set | (overflow_err & ~err_clr);
            underflow_err <= unf_set | (underflow_err & ~err_clr);
        end
    end

    // Read stage boundary: valid travels with the registered read word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= rd_ok;
    end

    fifo_mem_2p #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk       (clk),
        .rst       (reset),
        .wr_en     (wr_ok),
        .wr_addr   (wr_ptr),
        .wr_data   (FIFO_data_in),
        .rd_en     (rd_ok),
        .rd_addr   (rd_ptr),
        .rd_data_p1(FIFO_data_out)
    );

    assign valid_out = vld_p1;
endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// Scoreboard bench for fifo_flow_ctrl: queue-based reference model plus a decoupled output monitor.
module tb_fifo_flow_ctrl;
    localparam int DW    = 10;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [DW-1:0] din = '0;
    logic [AW:0]   af_th = 4'd6;
    logic [AW:0]   ae_th = 4'd1;
    logic          err_clr = 1'b0;
    logic [DW-1:0] dout;
    logic          valid_out;
    logic [AW:0]   fifo_count;
    logic          full, empty, almost_full, almost_empty, overflow_err, underflow_err;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] m_q[$];
    logic [DW-1:0] exp_q[$];
    bit            m_ovf = 0;
    bit            m_unf = 0;
    bit            m_vld = 0;

    fifo_flow_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .push           (push),
        .pop            (pop),
        .FIFO_data_in   (din),
        .almost_full_th (af_th),
        .almost_empty_th(ae_th),
        .err_clr        (err_clr),
        .FIFO_data_out  (dout),
        .valid_out      (valid_out),
        .fifo_count     (fifo_count),
        .full           (full),
        .empty          (empty),
        .almost_full    (almost_full),
        .almost_empty   (almost_empty),
        .overflow_err   (overflow_err),
        .underflow_err  (underflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_status();
        int n;
        n = m_q.size();
        chk("count", 32'(fifo_count), 32'(n));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("almost_full", 32'(almost_full), 32'(n >= int'(af_th)));
        chk("almost_empty", 32'(almost_empty), 32'(n <= int'(ae_th)));
        chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
        chk("underflow_err", 32'(underflow_err), 32'(m_unf));
        chk("valid_out", 32'(valid_out), 32'(m_vld));
    endtask

    // Called at a falling edge: drives one cycle of stimulus and updates the model at the rising edge.
    task automatic step(input bit p, input bit q, input logic [DW-1:0] d, input bit c);
        bit full_now, empty_now, wr_acc, rd_acc;
        push = p; pop = q; din = d; err_clr = c;
        full_now  = (m_q.size() == DEPTH);
        empty_now = (m_q.size() == 0);
        rd_acc = q && !empty_now;
        wr_acc = p && (!full_now || q);
        @(posedge clk);
        if (rd_acc) exp_q.push_back(m_q.pop_front());
        if (wr_acc) m_q.push_back(d);
        m_ovf = (p && full_now && !q) || (m_ovf && !c);
        m_unf = (q && empty_now) || (m_unf && !c);
        m_vld = rd_acc;
        @(negedge clk);
        push = 0; pop = 0; err_clr = 0;
        check_status();
    endtask

    // Monitor: every presented word must be the oldest outstanding expected word.
    always @(negedge clk) begin
        if (!reset && valid_out) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid actual=%0h required=none", dout);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (dout !== e) begin
                    failures++;
                    $display("FAIL read_data actual=%0h expected=%0h at %0t", dout, e, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] seq [4];
        seq[0] = 10'h090; seq[1] = 10'h1A9; seq[2] = 10'h239; seq[3] = 10'h04F;

        // Reset held for 3 cycles
        repeat (3) @(negedge clk);
        check_status();
        chk("reset_dout", 32'(dout), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check_status();

        // Ordered push/pop
        for (int i = 0; i < 4; i++) step(1, 0, seq[i], 0);
        for (int i = 0; i < 4; i++) step(0, 1, '0, 0);

        // Overfill: 9 pushes into an 8-deep FIFO
        for (int i = 0; i < 9; i++) step(1, 0, DW'(10'h300 + i), 0);
        // Full with simultaneous push+pop for 10 cycles
        for (int i = 0; i < 10; i++) step(1, 1, DW'(10'h150 + i), 0);
        for (int i = 0; i < 8; i++) step(0, 1, '0, 0);
        step(0, 1, '0, 0);

        // err_clr then empty push+pop
        step(0, 0, '0, 1);
        step(1, 1, 10'h2C3, 0);
        step(0, 1, '0, 0);
        // err_clr in the same cycle as a new underflow: set wins
        step(0, 1, '0, 1);
        step(0, 0, '0, 1);

        // Asynchronous reset while holding 5 words
        for (int i = 0; i < 5; i++) step(1, 0, DW'(10'h0A0 + i), 0);
        #2 reset = 1'b1;
        #1;
        m_q.delete();
        m_ovf = 0; m_unf = 0; m_vld = 0;
        check_status();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) step(0, 1, '0, 0);
        step(0, 0, '0, 1);

        // Randomized traffic with occasional threshold changes
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                af_th = 4'($urandom_range(0, 15));
                ae_th = 4'($urandom_range(0, 15));
            end
            step(bit'($urandom_range(0, 99) < 55), bit'($urandom_range(0, 99) < 50),
                 DW'($urandom), bit'($urandom_range(0, 99) < 5));
        end
        for (int i = 0; i < DEPTH + 1; i++) step(0, 1, '0, 0);

        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
